// File: rtl/pe_dbuf.sv
// pe_dbuf: weight-stationary systolic processing element with banked
// (double-buffered) weight storage. A shadow bank loads while the active
// bank computes; an in-band swap pulse moves down the column with the data.
//
// Optional feature macro: PE_SAT_EN
//   defined   -> psum saturates to the signed BIT_PSUM range, Ovf_Out flags it
//   undefined -> psum wraps modulo 2^BIT_PSUM, Ovf_Out stays 0
module pe_dbuf #(
  parameter int  BIT_DATA   = 8,
  parameter int  BIT_PSUM   = 24,
  parameter int  BIT_ROW_ID = 4,
  parameter int  BIT_ADDR   = 8,
  parameter int  BIT_VALID  = 1,
  parameter int  NUM_WBANK  = 2,
  localparam int BIT_BANK   = $clog2(NUM_WBANK)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  Stall,
  input  logic                  Mode_I_Signed,
  input  logic [BIT_ROW_ID-1:0] Row_ID,
  input  logic [BIT_DATA-1:0]   Data_I_In,
  output logic [BIT_DATA-1:0]   Data_I_Out,
  input  logic [BIT_DATA-1:0]   Data_W_In,
  output logic [BIT_DATA-1:0]   Data_W_Out,
  input  logic                  EN_W_In,
  output logic                  EN_W_Out,
  input  logic [BIT_ROW_ID-1:0] EN_ID_In,
  output logic [BIT_ROW_ID-1:0] EN_ID_Out,
  input  logic [BIT_BANK-1:0]   Bank_W_In,
  output logic [BIT_BANK-1:0]   Bank_W_Out,
  input  logic                  Swap_In,
  output logic                  Swap_Out,
  input  logic [BIT_PSUM-1:0]   Psum_In,
  output logic [BIT_PSUM-1:0]   Psum_Out,
  input  logic [BIT_ADDR-1:0]   Addr_P_In,
  output logic [BIT_ADDR-1:0]   Addr_P_Out,
  input  logic [BIT_VALID-1:0]  Valid_P_In,
  output logic [BIT_VALID-1:0]  Valid_P_Out,
  output logic [BIT_BANK-1:0]   Active_Bank,
  output logic                  Ovf_Out
);

  // Product width: (BIT_DATA+1)-bit extended activation times BIT_DATA weight.
  localparam int PW = 2 * BIT_DATA + 1;
`ifdef PE_SAT_EN
  // One guard bit above the psum range to detect overflow.
  localparam int SW = BIT_PSUM + 1;
`else
  localparam int SW = BIT_PSUM;
`endif

  // Forwarded pipeline registers.
  logic [BIT_DATA-1:0]   data_i_q, data_w_q;
  logic                  en_w_q, swap_q, ovf_q;
  logic [BIT_ROW_ID-1:0] en_id_q;
  logic [BIT_BANK-1:0]   bank_w_q, active_bank_q;
  logic [BIT_PSUM-1:0]   psum_q;
  logic [BIT_ADDR-1:0]   addr_q;
  logic [BIT_VALID-1:0]  valid_q;

  // Weight banks.
  logic [BIT_DATA-1:0] wbank_q [NUM_WBANK];

  // MAC datapath.
  logic signed [BIT_DATA:0]   ext_i;
  logic signed [BIT_DATA-1:0] w_act;
  logic signed [PW-1:0]       prod;
  logic signed [SW-1:0]       sum;
  logic [BIT_PSUM-1:0]        psum_d;
  logic                       ovf_d;
  logic                       wr_hit;

  assign wr_hit = EN_W_In && (EN_ID_In == Row_ID);

  // Multiply-accumulate with the currently active weight; bubbles pass psum through.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    psum_d = Psum_In;
    ovf_d  = 1'b0;
    ext_i  = Mode_I_Signed ? {Data_I_In[BIT_DATA-1], Data_I_In} : {1'b0, Data_I_In};
    w_act  = wbank_q[active_bank_q];
    // Size casts of signed operands sign-extend, so the product is exact.
    prod   = PW'(ext_i) * PW'(w_act);
    sum    = SW'(prod) + SW'($signed(Psum_In));
    if (Valid_P_In != '0) begin
`ifdef PE_SAT_EN
      if (sum[BIT_PSUM] != sum[BIT_PSUM-1]) begin
        psum_d = sum[BIT_PSUM] ? {1'b1, {(BIT_PSUM-1){1'b0}}}
                               : {1'b0, {(BIT_PSUM-1){1'b1}}};
        ovf_d  = 1'b1;
      end else begin
        psum_d = sum[BIT_PSUM-1:0];
      end
`else
      psum_d = sum;
`endif
    end
  end

  // Forwarding and psum pipeline stage; Stall freezes everything.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      data_i_q <= '0;
      data_w_q <= '0;
      en_w_q   <= 1'b0;
      en_id_q  <= '0;
      bank_w_q <= '0;
      swap_q   <= 1'b0;
      psum_q   <= '0;
      addr_q   <= '0;
      valid_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (!Stall) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      data_i_q <= Data_I_In;
      data_w_q <= Data_W_In;
      en_w_q   <= EN_W_In;
      en_id_q  <= EN_ID_In;
      bank_w_q <= Bank_W_In;
      swap_q   <= Swap_In;
      psum_q   <= psum_d;
      addr_q   <= Addr_P_In;
      valid_q  <= Valid_P_In;
      ovf_q    <= ovf_d;
    end
  end

  // Weight bank writes; an out-of-range bank index matches no bank and is dropped.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      // NOTE: the banks are architecturally visible after reset (first MAC uses
      // W=0), so they are reset like ordinary registers rather than left as RAM.
      for (int b = 0; b < NUM_WBANK; b++) wbank_q[b] <= '0;
    end else if (!Stall && wr_hit) begin
      for (int b = 0; b < NUM_WBANK; b++) begin
        if (Bank_W_In == BIT_BANK'(b)) wbank_q[b] <= Data_W_In;
      end
    end
  end

  // Active bank pointer advances on each swap pulse, wrapping at NUM_WBANK.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      active_bank_q <= '0;
    end else if (!Stall && Swap_In) begin
      active_bank_q <= (active_bank_q == BIT_BANK'(NUM_WBANK - 1)) ? '0
                       : active_bank_q + BIT_BANK'(1);
    end
  end

  assign Data_I_Out  = data_i_q;
  assign Data_W_Out  = data_w_q;
  assign EN_W_Out    = en_w_q;
  assign EN_ID_Out   = en_id_q;
  assign Bank_W_Out  = bank_w_q;
  assign Swap_Out    = swap_q;
  assign Psum_Out    = psum_q;
  assign Addr_P_Out  = addr_q;
  assign Valid_P_Out = valid_q;
  assign Active_Bank = active_bank_q;
  assign Ovf_Out     = ovf_q;

endmodule

// File: tb/tb_pe_dbuf.sv
// Testbench for pe_dbuf (default parameters, Row_ID = 2). Expected values
// come from directed constants and from an arithmetic reference model.
module tb_pe_dbuf;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        Stall, Mode_I_Signed;
  logic [3:0]  Row_ID;
  logic [7:0]  Data_I_In, Data_I_Out, Data_W_In, Data_W_Out;
  logic        EN_W_In, EN_W_Out;
  logic [3:0]  EN_ID_In, EN_ID_Out;
  logic [0:0]  Bank_W_In, Bank_W_Out, Active_Bank;
  logic        Swap_In, Swap_Out;
  logic [23:0] Psum_In, Psum_Out;
  logic [7:0]  Addr_P_In, Addr_P_Out;
  logic [0:0]  Valid_P_In, Valid_P_Out;
  logic        Ovf_Out;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  logic signed [7:0] w_m [2];
  int          act_m;
  logic [7:0]  exp_data_i, exp_data_w, exp_addr;
  logic        exp_en_w, exp_swap, exp_ovf;
  logic [3:0]  exp_en_id;
  logic [0:0]  exp_bank_w, exp_valid;
  logic [23:0] exp_psum;

  pe_dbuf dut (
    .CLK(CLK), .RSTN(RSTN), .Stall(Stall), .Mode_I_Signed(Mode_I_Signed),
    .Row_ID(Row_ID),
    .Data_I_In(Data_I_In), .Data_I_Out(Data_I_Out),
    .Data_W_In(Data_W_In), .Data_W_Out(Data_W_Out),
    .EN_W_In(EN_W_In), .EN_W_Out(EN_W_Out),
    .EN_ID_In(EN_ID_In), .EN_ID_Out(EN_ID_Out),
    .Bank_W_In(Bank_W_In), .Bank_W_Out(Bank_W_Out),
    .Swap_In(Swap_In), .Swap_Out(Swap_Out),
    .Psum_In(Psum_In), .Psum_Out(Psum_Out),
    .Addr_P_In(Addr_P_In), .Addr_P_Out(Addr_P_Out),
    .Valid_P_In(Valid_P_In), .Valid_P_Out(Valid_P_Out),
    .Active_Bank(Active_Bank), .Ovf_Out(Ovf_Out)
  );

  always #5 CLK = ~CLK;

  // Integer-arithmetic MAC: extend, multiply, add, then wrap or clamp.
  function automatic void model_mac(input logic [7:0] i, input logic signed [7:0] w,
                                    input logic [23:0] p, input logic sgn,
                                    output logic [23:0] r, output logic o);
    longint iv, s;
    iv = sgn ? longint'($signed(i)) : longint'(i);
    s  = iv * longint'(w) + longint'($signed(p));
    o  = 1'b0;
`ifdef PE_SAT_EN
    if (s > 64'sd8388607) begin
      r = 24'h7FFFFF; o = 1'b1;
    end else if (s < -64'sd8388608) begin
      r = 24'h800000; o = 1'b1;
    end else begin
      r = s[23:0];
    end
`else
    r = s[23:0];
`endif
  endfunction

  function automatic void model_reset();
    w_m[0] = '0; w_m[1] = '0; act_m = 0;
    exp_data_i = '0; exp_data_w = '0; exp_addr = '0; exp_en_w = 0; exp_swap = 0;
    exp_ovf = 0; exp_en_id = '0; exp_bank_w = '0; exp_valid = '0; exp_psum = '0;
  endfunction

  // Advance one clock, updating the model with the inputs sampled at the edge;
  // outputs are then observed 1 time unit after the edge.
  task automatic tick();
    logic [23:0] r;
    logic o;
    @(posedge CLK);
    if (RSTN && !Stall) begin
      model_mac(Data_I_In, w_m[act_m], Psum_In, Mode_I_Signed, r, o);
      exp_data_i = Data_I_In;  exp_data_w = Data_W_In; exp_en_w = EN_W_In;
      exp_en_id  = EN_ID_In;   exp_bank_w = Bank_W_In; exp_swap = Swap_In;
      exp_addr   = Addr_P_In;  exp_valid  = Valid_P_In;
      exp_psum   = (Valid_P_In != 0) ? r : Psum_In;
      exp_ovf    = (Valid_P_In != 0) ? o : 1'b0;
      if (EN_W_In && EN_ID_In == Row_ID) w_m[Bank_W_In] = Data_W_In;
      if (Swap_In) act_m = (act_m + 1) % 2;
    end
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 0; EN_W_In = 0; Swap_In = 0; EN_ID_In = 0; Bank_W_In = 0;
    Data_W_In = 0; Data_I_In = 0; Psum_In = 0; Addr_P_In = 0; Valid_P_In = 0;
  endtask

  task automatic write_w(input logic [0:0] bank, input logic [7:0] val);
    EN_W_In = 1; EN_ID_In = Row_ID; Bank_W_In = bank; Data_W_In = val;
    Valid_P_In = 0;
    tick();
    EN_W_In = 0;
  endtask

  task automatic test_reset();
    logic [23:0] r;
    // Power-up reset, before any clock edge.
    #2;
    tests_run++;
    if ({Psum_Out, Data_I_Out, Data_W_Out, Addr_P_Out, Active_Bank, Ovf_Out, Swap_Out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_powerup: outputs not zero psum=%h act=%0d", Psum_Out, Active_Bank);
    end
    @(negedge CLK); RSTN = 1;
    // Traffic: load bank0, swap to bank1, stream a few MACs.
    write_w(0, 8'd7);
    write_w(1, 8'd3);
    Swap_In = 1; tick(); Swap_In = 0;
    Data_I_In = 8'd4; Psum_In = 24'd11; Valid_P_In = 1; Addr_P_In = 8'h55;
    Data_W_In = 8'h22; Mode_I_Signed = 1;
    tick(); tick();
    // Drop reset mid-cycle, away from any edge.
    #3; RSTN = 0; #1;
    model_reset();
    tests_run++;
    if ({Psum_Out, Data_I_Out, Data_W_Out, Addr_P_Out, Valid_P_Out, EN_W_Out, EN_ID_Out,
         Bank_W_Out, Swap_Out, Ovf_Out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: outputs psum=%h data_i=%h addr=%h, want all 0",
               Psum_Out, Data_I_Out, Addr_P_Out);
    end
    tests_run++;
    if (Active_Bank !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_active_bank: got %0d want 0", Active_Bank);
    end
    @(negedge CLK); RSTN = 1;
    idle_inputs();
    Psum_In = 24'd5; Data_I_In = 8'd9; Valid_P_In = 1;
    tick();
    model_mac(8'd9, 8'sd0, 24'd5, Mode_I_Signed, r, exp_ovf);
    tests_run++;
    if (Psum_Out !== 24'd5) begin
      tests_failed++;
      $display("FAIL reset_first_mac: psum got %0d want 5", Psum_Out);
    end
  endtask

  task automatic test_double_buffer();
    idle_inputs();
    write_w(0, 8'd5);
    Data_I_In = 8'd10; Psum_In = 24'd100; Valid_P_In = 1;
    tick();
    tests_run++;
    if (Psum_Out !== 24'd150) begin
      tests_failed++; $display("FAIL dbuf_bank0: psum got %0d want 150", Psum_Out);
    end
    EN_W_In = 1; EN_ID_In = 4'd2; Bank_W_In = 1; Data_W_In = 8'hFD;  // -3 into shadow
    tick();
    tests_run++;
    if (Psum_Out !== 24'd150) begin
      tests_failed++; $display("FAIL dbuf_shadow_write: psum got %0d want 150", Psum_Out);
    end
    EN_ID_In = 4'd3; Data_W_In = 8'd77;                               // other row: ignored
    tick();
    EN_W_In = 0; Swap_In = 1;
    tick();
    tests_run++;
    if (Psum_Out !== 24'd150 || Swap_Out !== 1'b1) begin
      tests_failed++;
      $display("FAIL dbuf_swap_edge: psum=%0d swap_out=%b want 150/1", Psum_Out, Swap_Out);
    end
    Swap_In = 0;
    tick();
    tests_run++;
    if (Psum_Out !== 24'd70 || Active_Bank !== 1'b1 || Swap_Out !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbuf_after_swap: psum=%0d act=%0d swap_out=%b want 70/1/0",
               Psum_Out, Active_Bank, Swap_Out);
    end
  endtask

  task automatic test_signedness();
    idle_inputs();
    write_w(1'(act_m), 8'd2);
    Data_I_In = 8'hFF; Psum_In = 0; Valid_P_In = 1; Mode_I_Signed = 0;
    tick();
    tests_run++;
    if (Psum_Out !== 24'd510) begin
      tests_failed++; $display("FAIL sign_unsigned: psum got %0d want 510", Psum_Out);
    end
    Mode_I_Signed = 1;
    tick();
    tests_run++;
    if (Psum_Out !== 24'hFFFFFE) begin
      tests_failed++; $display("FAIL sign_signed: psum got %h want fffffe", Psum_Out);
    end
  endtask

  task automatic test_bubble();
    idle_inputs();
    write_w(1'(act_m), 8'd5);
    Valid_P_In = 0; Psum_In = 24'd7; Addr_P_In = 8'h3C; Data_I_In = 8'd10;
    tick();
    tests_run++;
    if (Psum_Out !== 24'd7 || Addr_P_Out !== 8'h3C || Valid_P_Out !== 1'b0 || Ovf_Out !== 1'b0) begin
      tests_failed++;
      $display("FAIL bubble: psum=%0d addr=%h valid=%b ovf=%b want 7/3c/0/0",
               Psum_Out, Addr_P_Out, Valid_P_Out, Ovf_Out);
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    Data_I_In = 8'd3; Psum_In = 24'd40; Valid_P_In = 1; Addr_P_In = 8'h11;
    tick();
    Stall = 1;
    for (int c = 0; c < 3; c++) begin
      Data_I_In = 8'($urandom); Data_W_In = 8'($urandom); Psum_In = 24'($urandom);
      Addr_P_In = 8'($urandom); Valid_P_In = 1'($urandom); Mode_I_Signed = 1'($urandom);
      EN_W_In = 1; EN_ID_In = Row_ID; Bank_W_In = 1'(c); Swap_In = 1;
      tick();
      tests_run++;
      if (Psum_Out !== exp_psum || Data_I_Out !== exp_data_i || Addr_P_Out !== exp_addr ||
          Swap_Out !== exp_swap || EN_W_Out !== exp_en_w || Active_Bank !== 1'(act_m)) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: psum=%h act=%0d want psum=%h act=%0d",
                 c, Psum_Out, Active_Bank, exp_psum, act_m);
      end
    end
    Stall = 0; EN_W_In = 0; Swap_In = 0; Valid_P_In = 1;
    for (int c = 0; c < 2; c++) begin
      Data_I_In = 8'($urandom); Psum_In = 24'($urandom_range(1000));
      tick();
      tests_run++;
      if (Psum_Out !== exp_psum || Active_Bank !== 1'(act_m)) begin
        tests_failed++;
        $display("FAIL stall_release[%0d]: psum=%h act=%0d want %h/%0d",
                 c, Psum_Out, Active_Bank, exp_psum, act_m);
      end
    end
  endtask

  task automatic test_overflow();
    idle_inputs();
    write_w(1'(act_m), 8'd1);
    Psum_In = 24'h7FFFFF; Data_I_In = 8'd1; Valid_P_In = 1;
    tick();
    tests_run++;
`ifdef PE_SAT_EN
    if (Psum_Out !== 24'h7FFFFF || Ovf_Out !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_sat: psum=%h ovf=%b want 7fffff/1", Psum_Out, Ovf_Out);
    end
`else
    if (Psum_Out !== 24'h800000 || Ovf_Out !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_wrap: psum=%h ovf=%b want 800000/0", Psum_Out, Ovf_Out);
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      Stall = ($urandom_range(9) == 0); Mode_I_Signed = 1'($urandom);
      Data_I_In = 8'($urandom); Data_W_In = 8'($urandom);
      EN_W_In = 1'($urandom); EN_ID_In = 4'($urandom_range(1, 3)); Bank_W_In = 1'($urandom);
      Swap_In = ($urandom_range(7) == 0); Addr_P_In = 8'($urandom);
      Valid_P_In = ($urandom_range(4) != 0);
      Psum_In = ($urandom_range(3) == 0) ? 24'($urandom) : 24'($urandom_range(20000));
      tick();
      tests_run++;
      if (Psum_Out !== exp_psum || Ovf_Out !== exp_ovf || Active_Bank !== 1'(act_m) ||
          {Data_I_Out, Data_W_Out, EN_W_Out, EN_ID_Out, Bank_W_Out, Swap_Out, Addr_P_Out, Valid_P_Out} !==
          {exp_data_i, exp_data_w, exp_en_w, exp_en_id, exp_bank_w, exp_swap, exp_addr, exp_valid}) begin
        tests_failed++;
        $display("FAIL random[%0d]: psum=%h ovf=%b act=%0d want %h/%b/%0d",
                 c, Psum_Out, Ovf_Out, Active_Bank, exp_psum, exp_ovf, act_m);
      end
    end
    Stall = 0;
  endtask

  initial begin
    RSTN = 0; Row_ID = 4'd2; Mode_I_Signed = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_double_buffer();
    test_signedness();
    test_bubble();
    test_stall();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
